// File: rtl/lfsr_noise_gen.sv
// Multi-channel Galois LFSR noise source: shared runtime-loadable feedback mask,
// salted per-channel seeds, STEPS shifts per sample and a valid/ready output bus.
module lfsr_noise_gen #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned OUT_BITS     = 16,
    parameter int unsigned STEPS        = 1,
    parameter logic [31:0] DEFAULT_POLY = 32'hB4000000,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE12345
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         signed_mode,
    input  logic                         cfg_load,
    input  logic [WIDTH-1:0]             cfg_poly,
    input  logic [WIDTH-1:0]             cfg_seed,
    output logic                         cfg_ack,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_BITS-1:0] out_data,
    output logic [31:0]                  sample_cnt,
    output logic                         lock_err,
    output logic                         busy
);

    localparam logic [31:0]      SALT_MULT = 32'h9E3779B9;
    localparam int unsigned      SCW       = 7;
    localparam logic [SCW-1:0]   LAST_STEP = SCW'(STEPS - 1);
    localparam logic [WIDTH-1:0] POLY_MSB  = WIDTH'(32'h1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(32'h1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } fsm_e;

    function automatic logic [WIDTH-1:0] salt(input int unsigned c);
        logic [31:0] prod;
        prod = c * SALT_MULT;
        return prod[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] x);
        return (x == '0) ? ONE : x;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s,
                                                    input logic [WIDTH-1:0] p);
        return s[0] ? ((s >> 1) ^ p) : (s >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] reset_state(input int unsigned c);
        return seed_fix(DEFAULT_SEED[WIDTH-1:0] ^ salt(c));
    endfunction

    // Offset-binary becomes two's complement by flipping the sample MSB
    function automatic logic [OUT_BITS-1:0] to_sample(input logic [WIDTH-1:0] s,
                                                      input logic sm);
        return s[WIDTH-1 -: OUT_BITS] ^ (OUT_BITS'(sm) << (OUT_BITS - 1));
    endfunction

    fsm_e                                 fsm_r, fsm_s;
    logic [SCW-1:0]                       step_cnt_r, step_cnt_s;
    logic [WIDTH-1:0]                     poly_r, poly_s;
    logic [CHANNELS-1:0][WIDTH-1:0]       state_r, state_s, shifted_s;
    logic [CHANNELS-1:0]                  zero_s;
    logic                                 out_valid_r, out_valid_s;
    logic [CHANNELS*OUT_BITS-1:0]         out_data_r, out_data_s;
    logic                                 cfg_ack_r, cfg_ack_s;
    logic [31:0]                          sample_cnt_r;
    logic                                 lock_err_r, lock_err_s;
    logic                                 busy_r;
    logic                                 xfer_s;

    // Next-state logic: handshake, config load, stepping and zero-lock recovery
    always_comb begin
        xfer_s      = out_valid_r && out_ready;
        fsm_s       = fsm_r;
        step_cnt_s  = step_cnt_r;
        poly_s      = poly_r;
        state_s     = state_r;
        out_valid_s = out_valid_r && !out_ready;
        out_data_s  = out_data_r;
        cfg_ack_s   = 1'b0;
        zero_s      = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            shifted_s[c] = lfsr_shift(state_r[c], poly_r);
        end

        case (fsm_r)
            ST_IDLE: begin
                if (cfg_load) begin
                    poly_s = cfg_poly | POLY_MSB;
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        state_s[c] = seed_fix(cfg_seed ^ salt(c));
                    end
                    out_valid_s = 1'b0;
                    cfg_ack_s   = 1'b1;
                    fsm_s       = ST_IDLE;
                end else if (enable && (!out_valid_r || out_ready)) begin
                    fsm_s      = ST_STEP;
                    step_cnt_s = '0;
                end else begin
                    fsm_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_s    = shifted_s;
                step_cnt_s = step_cnt_r + SCW'(1);
                if (step_cnt_r == LAST_STEP) begin
                    fsm_s       = ST_IDLE;
                    out_valid_s = 1'b1;
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        out_data_s[c*OUT_BITS +: OUT_BITS] = to_sample(shifted_s[c], signed_mode);
                    end
                end else begin
                    fsm_s = ST_STEP;
                end
            end
            default: begin
                fsm_s = ST_IDLE;
            end
        endcase

        // A zero state would lock the LFSR forever; reseed that channel
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            zero_s[c]  = (state_r[c] == '0);
            state_s[c] = zero_s[c] ? reset_state(c) : state_s[c];
        end
        lock_err_s = lock_err_r | (|zero_s);
    end

    // Registered state and outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r      <= ST_IDLE;
            step_cnt_r <= '0;
            poly_r     <= DEFAULT_POLY[WIDTH-1:0] | POLY_MSB;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_r[c] <= reset_state(c);
            end
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            cfg_ack_r    <= 1'b0;
            sample_cnt_r <= 32'd0;
            lock_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            fsm_r        <= fsm_s;
            step_cnt_r   <= step_cnt_s;
            poly_r       <= poly_s;
            state_r      <= state_s;
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            cfg_ack_r    <= cfg_ack_s;
            sample_cnt_r <= sample_cnt_r + (xfer_s ? 32'd1 : 32'd0);
            lock_err_r   <= lock_err_s;
            busy_r       <= (fsm_s == ST_STEP);
        end
    end

    assign cfg_ack    = cfg_ack_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign sample_cnt = sample_cnt_r;
    assign lock_err   = lock_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Self-checking bench for lfsr_noise_gen: known-answer table, directed corner
// sequences and randomized handshake traffic against a sample-level model.
module tb_lfsr_noise_gen;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int OB = 16;
    localparam int DW = CH * OB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: STEPS = 1
    logic          reset, enable, signed_mode, cfg_load, out_ready;
    logic [W-1:0]  cfg_poly, cfg_seed;
    logic          cfg_ack, out_valid, lock_err, busy;
    logic [DW-1:0] out_data;
    logic [31:0]   sample_cnt;

    // DUT B: STEPS = 4
    logic          reset_b, enable_b, signed_mode_b, cfg_load_b, out_ready_b;
    logic [W-1:0]  cfg_poly_b, cfg_seed_b;
    logic          cfg_ack_b, out_valid_b, lock_err_b, busy_b;
    logic [DW-1:0] out_data_b;
    logic [31:0]   sample_cnt_b;

    lfsr_noise_gen #(.WIDTH(W), .CHANNELS(CH), .OUT_BITS(OB), .STEPS(1)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .signed_mode(signed_mode),
        .cfg_load(cfg_load), .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_ack(cfg_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sample_cnt(sample_cnt), .lock_err(lock_err), .busy(busy)
    );

    lfsr_noise_gen #(.WIDTH(W), .CHANNELS(CH), .OUT_BITS(OB), .STEPS(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .signed_mode(signed_mode_b),
        .cfg_load(cfg_load_b), .cfg_poly(cfg_poly_b), .cfg_seed(cfg_seed_b), .cfg_ack(cfg_ack_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .sample_cnt(sample_cnt_b), .lock_err(lock_err_b), .busy(busy_b)
    );

    typedef struct {
        logic        sm;
        logic [15:0] c0a;
        logic [15:0] c1a;
        logic [15:0] c0b;
        logic [15:0] c1b;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0]            m_state [CH];
    logic [31:0]            m_poly;
    logic [CH-1:0][W-1:0]   force_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_salt(input int c);
        logic [31:0] cc;
        cc = c;
        return cc * 32'h9E3779B9;
    endfunction

    function automatic logic [31:0] m_fix(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

    task automatic m_load(input logic [31:0] poly, input logic [31:0] seed);
        m_poly = poly | 32'h80000000;
        for (int c = 0; c < CH; c++) m_state[c] = m_fix(seed ^ m_salt(c));
    endtask

    task automatic m_reset();
        m_load(32'hB4000000, 32'hACE12345);
    endtask

    // Advance every channel by `steps` shifts and return the packed sample bus
    task automatic m_sample(input int steps, input logic sm, output logic [DW-1:0] d);
        for (int s = 0; s < steps; s++) begin
            for (int c = 0; c < CH; c++) begin
                if (m_state[c][0]) m_state[c] = (m_state[c] >> 1) ^ m_poly;
                else               m_state[c] = m_state[c] >> 1;
            end
        end
        d = '0;
        for (int c = 0; c < CH; c++) d[c*OB +: OB] = m_state[c][W-1 -: OB] ^ {sm, 15'd0};
    endtask

    task automatic reset_a();
        reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; out_ready = 1'b0;
        signed_mode = 1'b0; cfg_poly = 32'd0; cfg_seed = 32'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic reset_bb();
        reset_b = 1'b1; enable_b = 1'b0; cfg_load_b = 1'b0; out_ready_b = 1'b0;
        signed_mode_b = 1'b0; cfg_poly_b = 32'd0; cfg_seed_b = 32'd0;
        tick();
        reset_b = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        m_reset();
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_ack"}, 64'(cfg_ack), 64'd0);
        check({tag, "_cnt"}, 64'(sample_cnt), 64'd0);
        check({tag, "_lock"}, 64'(lock_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_poly"}, 64'(u_dut.poly_r), 64'h00000000B4000000);
        for (int c = 0; c < CH; c++) check({tag, "_state"}, 64'(u_dut.state_r[c]), 64'(m_state[c]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_d;
        vec_t          vecs [2];
        int            xfers;

        vecs[0] = '{sm: 1'b0, c0a: 16'hE270, c1a: 16'h196B, c0b: 16'h7138, c1b: 16'h0CB5};
        vecs[1] = '{sm: 1'b1, c0a: 16'h6270, c1a: 16'h996B, c0b: 16'hF138, c1b: 16'h8CB5};

        reset_b = 1'b1; enable_b = 1'b0; cfg_load_b = 1'b0; out_ready_b = 1'b0;
        signed_mode_b = 1'b0; cfg_poly_b = 32'd0; cfg_seed_b = 32'd0;
        reset_a();
        reset_bb();
        check_reset_a("rst");

        // Known-answer samples after reset, unsigned and signed
        for (int i = 0; i < 2; i++) begin
            reset_a();
            signed_mode = vecs[i].sm; enable = 1'b1; out_ready = 1'b1;
            tick();
            check("lat_t1_valid", 64'(out_valid), 64'd0);
            check("lat_t1_busy", 64'(busy), 64'd1);
            tick();
            check("lat_t2_valid", 64'(out_valid), 64'd1);
            check("s0_ch0", 64'(out_data[0 +: OB]), 64'(vecs[i].c0a));
            check("s0_ch1", 64'(out_data[OB +: OB]), 64'(vecs[i].c1a));
            tick();
            check("xfer_valid", 64'(out_valid), 64'd0);
            check("xfer_cnt", 64'(sample_cnt), 64'd1);
            tick();
            check("s1_valid", 64'(out_valid), 64'd1);
            check("s1_ch0", 64'(out_data[0 +: OB]), 64'(vecs[i].c0b));
            check("s1_ch1", 64'(out_data[OB +: OB]), 64'(vecs[i].c1b));
        end

        // Backpressure holds data, state and count
        reset_a(); m_reset();
        enable = 1'b1; out_ready = 1'b0;
        tick(); tick();
        m_sample(1, 1'b0, exp_d);
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_data", 64'(out_data), 64'(exp_d));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'(exp_d));
            check("bp_hold_cnt", 64'(sample_cnt), 64'd0);
            check("bp_no_shift", 64'(u_dut.state_r[0]), 64'(m_state[0]));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_cnt", 64'(sample_cnt), 64'd1);
        tick();
        m_sample(1, 1'b0, exp_d);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_data", 64'(out_data), 64'(exp_d));

        // Reset while a sample is pending, then replay from the start
        reset_a();
        check_reset_a("rst_pending");
        enable = 1'b1; out_ready = 1'b1;
        tick(); tick();
        check("replay_valid", 64'(out_valid), 64'd1);
        check("replay_ch0", 64'(out_data[0 +: OB]), 64'h0000_0000_0000_E270);

        // Config load in IDLE with a zero seed and a poly lacking its MSB
        reset_a();
        cfg_poly = 32'h34000000; cfg_seed = 32'd0; cfg_load = 1'b1;
        tick();
        m_load(32'h34000000, 32'd0);
        cfg_load = 1'b0;
        check("cfg_ack_pulse", 64'(cfg_ack), 64'd1);
        check("cfg_poly_msb", 64'(u_dut.poly_r), 64'h00000000B4000000);
        check("cfg_ch0_fixed", 64'(u_dut.state_r[0]), 64'd1);
        check("cfg_ch1_salt", 64'(u_dut.state_r[1]), 64'(m_state[1]));
        enable = 1'b1; out_ready = 1'b1;
        tick();
        check("cfg_ack_drop", 64'(cfg_ack), 64'd0);
        tick();
        m_sample(1, 1'b0, exp_d);
        check("cfg_sample_ch0", 64'(out_data[0 +: OB]), 64'h0000_0000_0000_B400);
        check("cfg_sample_all", 64'(out_data), 64'(exp_d));

        // Forced zero state recovers and latches lock_err until reset
        reset_a(); m_reset();
        force_val = u_dut.state_r;
        force_val[2] = '0;
        force u_dut.state_r = force_val;
        #1;
        release u_dut.state_r;
        check("zl_pre_flag", 64'(lock_err), 64'd0);
        tick();
        check("zl_restore", 64'(u_dut.state_r[2]), 64'(m_fix(32'hACE12345 ^ m_salt(2))));
        check("zl_other", 64'(u_dut.state_r[0]), 64'(m_state[0]));
        check("zl_flag", 64'(lock_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zl_sticky", 64'(lock_err), 64'd1);
        end
        reset_a();
        check("zl_cleared", 64'(lock_err), 64'd0);

        // STEPS=4: config load requested mid-STEP waits for IDLE
        reset_bb(); m_reset();
        enable_b = 1'b1; out_ready_b = 1'b1;
        tick();
        check("b_busy", 64'(busy_b), 64'd1);
        cfg_load_b = 1'b1; cfg_poly_b = 32'h34000000; cfg_seed_b = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_cfg_held_ack", 64'(cfg_ack_b), 64'd0);
            check("b_cfg_held_busy", 64'(busy_b), 64'd1);
        end
        tick();
        m_sample(4, 1'b0, exp_d);
        check("b_done_ack", 64'(cfg_ack_b), 64'd0);
        check("b_done_valid", 64'(out_valid_b), 64'd1);
        check("b_done_data", 64'(out_data_b), 64'(exp_d));
        tick();
        m_load(32'h34000000, 32'd0);
        cfg_load_b = 1'b0;
        check("b_ack", 64'(cfg_ack_b), 64'd1);
        check("b_ack_valid_clr", 64'(out_valid_b), 64'd0);
        check("b_ack_cnt", 64'(sample_cnt_b), 64'd1);
        check("b_poly", 64'(u_dut_b.poly_r), 64'h00000000B4000000);
        check("b_ch0", 64'(u_dut_b.state_r[0]), 64'd1);
        tick();
        check("b_ack_drop", 64'(cfg_ack_b), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_lat_valid", 64'(out_valid_b), 64'd0);
        end
        tick();
        m_sample(4, 1'b0, exp_d);
        check("b_cfg_sample_valid", 64'(out_valid_b), 64'd1);
        check("b_cfg_sample_data", 64'(out_data_b), 64'(exp_d));
        tick(); tick();
        check("b_midstep_busy", 64'(busy_b), 64'd1);
        reset_bb(); m_reset();
        check("b_rst_valid", 64'(out_valid_b), 64'd0);
        check("b_rst_busy", 64'(busy_b), 64'd0);
        check("b_rst_cnt", 64'(sample_cnt_b), 64'd0);
        check("b_rst_data", 64'(out_data_b), 64'd0);
        check("b_rst_state", 64'(u_dut_b.state_r[1]), 64'(m_state[1]));
        enable_b = 1'b1; out_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_replay_wait", 64'(out_valid_b), 64'd0);
        end
        tick();
        m_sample(4, 1'b0, exp_d);
        check("b_replay_valid", 64'(out_valid_b), 64'd1);
        check("b_replay_data", 64'(out_data_b), 64'(exp_d));
        enable_b = 1'b0;

        // Random enable/ready traffic scored against the model
        for (int ph = 0; ph < 2; ph++) begin
            reset_a(); m_reset();
            signed_mode = ph[0];
            xfers = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                enable    = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                if (out_valid && out_ready) begin
                    m_sample(1, ph[0], exp_d);
                    check("rand_data", 64'(out_data), 64'(exp_d));
                    xfers++;
                end
                tick();
                check("rand_cnt", 64'(sample_cnt), 64'(xfers));
            end
            check("rand_progress", 64'(xfers >= 100), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
